// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes four BCD digits onto a common-anode 4-digit 7-segment
// display. Each digit slot starts with a short all-anodes-off window to
// suppress ghosting between digits. Per-digit blink, decimal points and
// leading-zero suppression of digit 3 are supported. All inputs are sampled
// into shadow registers once per frame, so a digit never changes mid-scan.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   digits      four BCD codes, [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   blink_mask  bit i set: digit i blanked during the blink-off phase
//   dp_mask     bit i set: decimal point lit on digit i
//   lz_blank    suppress digit 3 when its code is 0
//   an          anode enables, active-low, at most one low at a time
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100_000,    // clocks per digit slot, >= 2
    parameter int BLANK_CYCLES = 1_000,      // blank clocks at slot start
    parameter int BLINK_DIV    = 50_000_000  // clocks per blink phase, >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

    // Per-frame snapshot of every display input.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blink_mask;
        logic [3:0]  dp_mask;
        logic        lz_blank;
    } shadow_t;

    // Active-low gfedcba pattern for one code; codes above 0xA show nothing.
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h3F;  // minus sign, g only
            default: decode = 7'h7F;
        endcase
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          bph_q, bph_d;
    shadow_t       shadow_q, shadow_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic       slot_last;
    logic       frame_end;
    logic [3:0] code;
    logic       blank;

    assign slot_last = (cnt_q == CNT_LAST);
    assign frame_end = slot_last && (idx_q == 2'd3);
    assign code      = shadow_q.digits[{idx_q, 2'b00} +: 4];

    // Blanking window, blink-off phase, or a suppressed leading zero.
    assign blank = (cnt_q < CNT_BLANK)
                || (shadow_q.blink_mask[idx_q] && bph_q)
                || ((idx_q == 2'd3) && shadow_q.lz_blank && (code == 4'd0));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        bcnt_d   = bcnt_q + BW'(1);
        bph_d    = bph_q;
        shadow_d = shadow_q;
        an_d     = 4'b1111;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;

        if (slot_last) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        // Inputs only take effect at a frame boundary.
        if (frame_end) begin
            shadow_d = {digits, blink_mask, dp_mask, lz_blank};
        end

        if (bcnt_q == BCNT_LAST) begin
            bcnt_d = '0;
            bph_d  = ~bph_q;
        end

        if (!blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decode(code);
            dp_d  = ~shadow_q.dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            bcnt_q   <= '0;
            bph_q    <= 1'b0;
            // NOTE: the snapshot registers are reset so the first frame shows a defined "0".
            shadow_q <= '0;
            an_q     <= 4'b1111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            bph_q    <= bph_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2,
// BLINK_DIV=64. Each slot lasts 8 clocks: 2 blank then 6 lit. A frame is
// 32 clocks, and the blink phase flips every 64 clocks. Inputs changed
// during frame N are captured on the last edge of frame N and appear in
// frame N+1. Expected segment codes are written out by hand.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    seg7_scan_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .BLINK_DIV    (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e);
        check({tag, "_an"},  {28'd0, an},  {28'd0, an_e});
        check({tag, "_seg"}, {25'd0, seg}, {25'd0, seg_e});
        check({tag, "_dp"},  {31'd0, dp},  {31'd0, dp_e});
    endtask

    // One full 8-clock slot: 2 blank clocks, then 6 lit (or 6 more blank).
    task automatic run_slot(input string tag, input logic [3:0] an_e, input logic lit,
                            input logic [6:0] seg_e, input logic dp_e);
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            if (j < 2 || !lit)
                check_out($sformatf("%s_c%0d", tag, j), 4'b1111, 7'h7F, 1'b1);
            else
                check_out($sformatf("%s_c%0d", tag, j), an_e, seg_e, dp_e);
        end
    endtask

    // segs = {seg3, seg2, seg1, seg0}; lit and dps are indexed by digit.
    task automatic run_frame(input string tag, input logic [3:0] lit,
                             input logic [27:0] segs, input logic [3:0] dps);
        logic [3:0] an_tab [4];
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 4; i++) begin
            run_slot($sformatf("%s_d%0d", tag, i), an_tab[i], lit[i],
                     segs[i*7 +: 7], dps[i]);
        end
    endtask

    // No clock may ever have two anodes enabled.
    always @(negedge clk) begin
        if (mon_en)
            check("onehot", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
    end

    initial begin
        rst        = 1'b1;
        digits     = 16'h1234;
        blink_mask = 4'b0000;
        dp_mask    = 4'b0000;
        lz_blank   = 1'b0;

        // Reset held for 5 clocks: display fully dark.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("reset%0d", k), 4'b1111, 7'h7F, 1'b1);
        end
        mon_en = 1'b1;
        rst    = 1'b0;

        // Frame 1: shadow still zero, every digit shows "0".
        run_frame("f1", 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

        // Frame 2: 1234 -> digit0=4, 1=3, 2=2, 3=1. Inputs change during digit 1.
        run_slot("f2_d0", 4'b1110, 1'b1, 7'h19, 1'b1);
        digits = 16'h5678;
        run_slot("f2_d1", 4'b1101, 1'b1, 7'h30, 1'b1);
        run_slot("f2_d2", 4'b1011, 1'b1, 7'h24, 1'b1);
        run_slot("f2_d3", 4'b0111, 1'b1, 7'h79, 1'b1);

        // Frame 3: 5678 -> 8,7,6,5. Blink setup captured at its end.
        digits     = 16'h1259;
        blink_mask = 4'b0011;
        run_frame("f3", 4'b1111, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111);

        // 1259 -> 9,5,2,1. Blink phase is off for frames 4 and 7 and on for 5 and 6.
        run_frame("f4_off", 4'b1100, {7'h79, 7'h24, 7'h12, 7'h10}, 4'b1111);
        run_frame("f5_on",  4'b1111, {7'h79, 7'h24, 7'h12, 7'h10}, 4'b1111);
        run_frame("f6_on",  4'b1111, {7'h79, 7'h24, 7'h12, 7'h10}, 4'b1111);
        digits     = 16'h0930;
        blink_mask = 4'b0000;
        lz_blank   = 1'b1;
        run_frame("f7_off", 4'b1100, {7'h79, 7'h24, 7'h12, 7'h10}, 4'b1111);

        // Frame 8: leading zero on digit 3 suppressed, digit 0 zero still shown.
        lz_blank = 1'b0;
        run_frame("f8_lz1", 4'b0111, {7'h40, 7'h10, 7'h30, 7'h40}, 4'b1111);

        // Frame 9: suppression off, digit 3 shows "0".
        digits  = 16'hFAC0;
        dp_mask = 4'b0100;
        run_frame("f9_lz0", 4'b1111, {7'h40, 7'h10, 7'h30, 7'h40}, 4'b1111);

        // Frame 10: FAC0 -> 0, C(blank pattern), A(minus)+dp, F(blank pattern).
        digits = 16'h0CA3;
        run_frame("f10_dp", 4'b1111, {7'h7F, 7'h3F, 7'h7F, 7'h40}, 4'b1011);

        // Frame 11: 0CA3 -> 3, A(minus), C+dp, 0.
        run_frame("f11_dp", 4'b1111, {7'h40, 7'h7F, 7'h3F, 7'h30}, 4'b1011);

        // Frame 12 interrupted by reset in the middle of digit 2.
        run_slot("f12_d0", 4'b1110, 1'b1, 7'h30, 1'b1);
        run_slot("f12_d1", 4'b1101, 1'b1, 7'h3F, 1'b1);
        digits = 16'h1111;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            if (j < 2)
                check_out($sformatf("f12_d2_c%0d", j), 4'b1111, 7'h7F, 1'b1);
            else
                check_out($sformatf("f12_d2_c%0d", j), 4'b1011, 7'h7F, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out("midrst", 4'b1111, 7'h7F, 1'b1);
        rst = 1'b0;

        // Scan restarts at digit 0 with a cleared shadow; pending 1111 waits a frame.
        run_frame("rst_f1", 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
        run_frame("rst_f2", 4'b1111, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1011);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
